// File: rtl/alu_issue_unit_if.sv
// alu_issue_unit_if: instruction handshake, ALU drive/result and debug read bundle
interface alu_issue_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        enable;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] register_data_1;
  logic [31:0] register_data_2;
  logic [31:0] register_data_out;
  logic        retire;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  modport slave (
    input  instr_valid, instruction, register_data_out, dbg_addr,
    output instr_ready, enable, funct3, funct7, register_data_1, register_data_2,
           retire, illegal, dbg_data
  );
  modport master (
    output instr_valid, instruction, register_data_out, dbg_addr,
    input  instr_ready, enable, funct3, funct7, register_data_1, register_data_2,
           retire, illegal, dbg_data
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: single-issue OP/OP-IMM decode, register read, ALU drive and writeback
module alu_issue_unit #(
  parameter int ALU_LATENCY = 1
) (
  input logic            clock,
  input logic            reset,
  alu_issue_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, ILL} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [6:0]  f7_q, f7_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] ins;
  logic [6:0]  opc;
  logic        is_op, is_imm, shift_imm;
  assign ins       = bus.instruction;
  assign opc       = ins[6:0];
  assign is_op     = opc == 7'b0110011;
  assign is_imm    = opc == 7'b0010011;
  assign shift_imm = ins[14:12] == 3'b001 || ins[14:12] == 3'b101;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    rf_d    = rf_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) state_d = (is_op || is_imm) ? ISSUE : ILL;
        if (bus.instr_valid && (is_op || is_imm)) begin
          f3_d  = ins[14:12];
          rd_d  = ins[11:7];
          op1_d = rf_q[ins[19:15]];
          op2_d = is_op ? rf_q[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
          f7_d  = (is_op || shift_imm) ? ins[31:25] : 7'h00;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 4'(ALU_LATENCY - 1);
      end
      WAIT: begin
        state_d = cnt_q == 4'd0 ? WB : WAIT;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        res_d   = cnt_q == 4'd0 ? bus.register_data_out : res_q;
      end
      WB: begin
        state_d = IDLE;
        if (rd_q != 5'd0) rf_d[rd_q] = res_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      rf_q    <= '{default: 32'h0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      rf_q    <= rf_d;
    end
  end
  assign bus.instr_ready     = state_q == IDLE && !reset;
  assign bus.enable          = state_q == ISSUE;
  assign bus.retire          = state_q == WB;
  assign bus.illegal         = state_q == ILL;
  assign bus.funct3          = f3_q;
  assign bus.funct7          = f7_q;
  assign bus.register_data_1 = op1_q;
  assign bus.register_data_2 = op2_q;
  assign bus.dbg_data        = bus.dbg_addr == 5'd0 ? 32'h0 : rf_q[bus.dbg_addr];
endmodule
